tour_cmd_seq: RTL and testbench
===============================

# tour_cmd_seq

Parametrised tour command sequencer. It sits between the tour solver and the command processor. It reads the solved 1-hot knight moves by index for an N×N board and splits each move into a vertical leg and a horizontal leg, each issued as a 16-bit command. Legs are handed over with a ready/clear handshake and a completion-paced flow. When no tour is active, UART/BLE commands pass straight through, and a UART abort command can terminate a running tour.

## Interface
- BOARD, 5: board edge length (3..8); NUM_MOVES = BOARD*BOARD-1.
- IDX_W, $clog2(BOARD*BOARD): width of mv_indx.
- FANFARE_LEG, 1: 1 = fanfare opcode on the horizontal (second) leg, 0 = on the vertical (first) leg.
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start_tour  in  1  pulse: solver done, begin issuing moves.
- move  in  8  1-hot move at mv_indx; valid the cycle after mv_indx changes.
- mv_indx  out  IDX_W  move index to solver; reset 0.
- cmd_UART  in  16  command from UART wrapper.
- cmd_rdy_UART  in  1  UART command valid.
- clr_cmd_rdy  in  1  command processor accepted cmd.
- send_resp  in  1  pulse: command processor finished current command.
- cmd  out  16  multiplexed command; reset 16'h0000.
- cmd_rdy  out  1  multiplexed command valid; reset 0.
- resp  out  8  8'hA5 done / 8'h5A in progress; reset 8'hA5.
- tour_busy  out  1  tour in progress; reset 0.
- tour_err  out  1  one-cycle pulse on an invalid move or abort; reset 0.

## Operation
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
  - Opcodes: 4'h2 = move, 4'h3 = move+fanfare, 4'hF = abort.
  - Headings: N = 8'h00, W = 8'h3F, S = 8'h7F, E = 8'hBF.
- Move decode as (dx,dy):
  - b0 (+1,+2), b1 (-1,+2), b2 (-2,+1), b3 (-2,-1)
  - b4 (-1,-2), b5 (+1,-2), b6 (+2,-1), b7 (+2,+1)
  - Vertical leg: heading N if dy>0, else S; squares = |dy|.
  - Horizontal leg: heading E if dx>0, else W; squares = |dx|.
- States: IDLE, LOAD, VERT, WAIT_V, HORZ, WAIT_H.
  - IDLE: cmd = cmd_UART and cmd_rdy = cmd_rdy_UART, both combinational; resp = A5. start_tour → LOAD, mv_indx = 0, tour_busy = 1.
  - LOAD: register move. If move is not 1-hot (including 0) → pulse tour_err, go to IDLE. Otherwise → VERT.
  - VERT: registered cmd = vertical leg, cmd_rdy = 1. On clr_cmd_rdy, cmd_rdy = 0 and go to WAIT_V.
  - WAIT_V: on send_resp → HORZ.
  - HORZ: same as VERT with the horizontal leg; clr_cmd_rdy → WAIT_H.
  - WAIT_H: on send_resp, if mv_indx == NUM_MOVES-1 → IDLE with tour_busy = 0. Otherwise mv_indx+1 → LOAD.
- resp is 5A during a tour. It is A5 in IDLE and in WAIT_H when mv_indx == NUM_MOVES-1, so the final leg reports done.
- Outside IDLE, cmd_rdy_UART is ignored unless cmd_UART[15:12] == 4'hF. Abort → IDLE, cmd_rdy = 0, tour_err pulse, mv_indx = 0.
- start_tour outside IDLE is ignored.
- Abort and send_resp in the same cycle: abort wins.
- clr_cmd_rdy outside VERT/HORZ is ignored.

## Timing
- start_tour high at edge k: LOAD from k, with mv_indx = 0. VERT from k+1, and cmd_rdy = 1 after edge k+1.
- clr_cmd_rdy at edge j drops cmd_rdy after j.
- send_resp in WAIT_H at edge j: mv_indx increments at j, and the next cmd_rdy follows at j+1.
- Per-move overhead: 2 cycles plus downstream latency.
- mv_indx never exceeds NUM_MOVES-1 and does not wrap.
- Asynchronous reset, including mid-tour, forces IDLE and all outputs to their reset values immediately.

## Structure
- Package tour_pkg holds:
  - opcode and heading localparams;
  - the state enum;
  - typedef cmd_t (packed opcode/heading/squares).
- One sub-module, tour_move_dec (combinational), takes move and FANFARE_LEG and produces the two cmd_t legs plus a valid flag.

## Test plan
- BOARD=5, start_tour with move = 8'h01, then clr_cmd_rdy/send_resp per leg → cmd 16'h2002, then 16'h3BF1; mv_indx 0→1.
- Move 8'h08 with FANFARE_LEG=0 → 16'h37F1, then 16'h23F2.
- Full 24-move tour with a random responder → exactly 48 commands; resp = A5 only in the final WAIT_H and in IDLE; tour_busy falls after the last send_resp.
- Move 8'h03 at index 5 → tour_err pulse, IDLE, UART passthrough resumes: cmd_UART 16'h2101 appears on cmd the same cycle.
- Abort 16'hF000 during WAIT_V of move 3 → IDLE next cycle, mv_indx = 0, cmd_rdy = 0; a non-abort UART command during the tour is ignored.
- rst asserted mid-VERT → cmd_rdy = 0, cmd = 0, resp = A5 asynchronously; a new start_tour restarts from index 0.

Source files
------------

// File: rtl/tour_pkg.sv
// rtl/tour_pkg.sv - shared opcodes, headings, FSM states and command layout for the tour sequencer
package tour_pkg;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;
    localparam logic [3:0] OP_ABORT   = 4'hF;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VERT,
        WAIT_V,
        HORZ,
        WAIT_H
    } state_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] heading;
        logic [3:0] squares;
    } cmd_t;

    function automatic logic is_one_hot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

endpackage

// File: rtl/tour_move_dec.sv
// rtl/tour_move_dec.sv - splits a 1-hot knight move into vertical and horizontal leg commands
module tour_move_dec
    import tour_pkg::*;
#(
    parameter bit FANFARE_LEG = 1'b1
) (
    input  logic [7:0] move_i,
    output cmd_t       vert_o,
    output cmd_t       horz_o,
    output logic       valid_o
);

    logic       north;
    logic       east;
    logic [3:0] vert_sq;
    logic [3:0] horz_sq;

    // Bits 0,1,4,5 are the long-vertical moves; the rest are long-horizontal.
    always_comb begin
        north   = move_i[0] | move_i[1] | move_i[2] | move_i[7];
        east    = move_i[0] | move_i[5] | move_i[6] | move_i[7];
        vert_sq = (move_i[0] | move_i[1] | move_i[4] | move_i[5]) ? 4'd2 : 4'd1;
        horz_sq = (move_i[2] | move_i[3] | move_i[6] | move_i[7]) ? 4'd2 : 4'd1;

        vert_o.opcode  = FANFARE_LEG ? OP_MOVE : OP_FANFARE;
        vert_o.heading = north ? HDG_N : HDG_S;
        vert_o.squares = vert_sq;

        horz_o.opcode  = FANFARE_LEG ? OP_FANFARE : OP_MOVE;
        horz_o.heading = east ? HDG_E : HDG_W;
        horz_o.squares = horz_sq;

        valid_o = is_one_hot(move_i);
    end

endmodule

// File: rtl/tour_cmd_seq.sv
// rtl/tour_cmd_seq.sv - issues solved knight-tour moves as paced two-leg commands, UART passthrough when idle
module tour_cmd_seq
    import tour_pkg::*;
#(
    parameter int BOARD       = 5,
    parameter int IDX_W       = $clog2(BOARD * BOARD),
    parameter bit FANFARE_LEG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    output logic [7:0]       resp,
    output logic             tour_busy,
    output logic             tour_err
);

    localparam int               NUM_MOVES = BOARD * BOARD - 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MOVES - 1);

    state_t           state_q;
    logic [IDX_W-1:0] mv_indx_q;
    cmd_t             cmd_q;
    cmd_t             horz_q;
    logic             cmd_rdy_q;
    logic             tour_busy_q;
    logic             tour_err_q;

    cmd_t vert_leg;
    cmd_t horz_leg;
    logic leg_valid;
    logic abort_req;

    tour_move_dec #(
        .FANFARE_LEG(FANFARE_LEG)
    ) u_dec (
        .move_i (move),
        .vert_o (vert_leg),
        .horz_o (horz_leg),
        .valid_o(leg_valid)
    );

    assign abort_req = cmd_rdy_UART && (cmd_UART[15:12] == OP_ABORT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mv_indx_q   <= '0;
            cmd_q       <= '0;
            horz_q      <= '0;
            cmd_rdy_q   <= 1'b0;
            tour_busy_q <= 1'b0;
            tour_err_q  <= 1'b0;
        end else begin
            tour_err_q <= 1'b0;
            if (state_q != IDLE && abort_req) begin
                state_q     <= IDLE;
                mv_indx_q   <= '0;
                cmd_rdy_q   <= 1'b0;
                tour_busy_q <= 1'b0;
                tour_err_q  <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_tour) begin
                            state_q     <= LOAD;
                            mv_indx_q   <= '0;
                            tour_busy_q <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (!leg_valid) begin
                            state_q     <= IDLE;
                            tour_busy_q <= 1'b0;
                            tour_err_q  <= 1'b1;
                        end else begin
                            // Horizontal leg is held until the vertical one completes.
                            cmd_q     <= vert_leg;
                            horz_q    <= horz_leg;
                            cmd_rdy_q <= 1'b1;
                            state_q   <= VERT;
                        end
                    end
                    VERT: begin
                        if (clr_cmd_rdy) begin
                            cmd_rdy_q <= 1'b0;
                            state_q   <= WAIT_V;
                        end
                    end
                    WAIT_V: begin
                        if (send_resp) begin
                            cmd_q     <= horz_q;
                            cmd_rdy_q <= 1'b1;
                            state_q   <= HORZ;
                        end
                    end
                    HORZ: begin
                        if (clr_cmd_rdy) begin
                            cmd_rdy_q <= 1'b0;
                            state_q   <= WAIT_H;
                        end
                    end
                    WAIT_H: begin
                        if (send_resp) begin
                            if (mv_indx_q == LAST_IDX) begin
                                state_q     <= IDLE;
                                tour_busy_q <= 1'b0;
                            end else begin
                                mv_indx_q <= mv_indx_q + 1'b1;
                                state_q   <= LOAD;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mv_indx   = mv_indx_q;
    assign cmd       = (state_q == IDLE) ? cmd_UART : cmd_q;
    assign cmd_rdy   = (state_q == IDLE) ? cmd_rdy_UART : cmd_rdy_q;
    assign tour_busy = tour_busy_q;
    assign tour_err  = tour_err_q;
    // The final leg reports done while it is still executing.
    assign resp      = ((state_q == IDLE) || (state_q == WAIT_H && mv_indx_q == LAST_IDX))
                       ? RESP_DONE : RESP_BUSY;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// tb/tb_tour_cmd_seq.sv - randomized self-checking bench for tour_cmd_seq against a behavioural model
module tb_tour_cmd_seq;

    localparam int BOARD     = 5;
    localparam int IDX_W     = $clog2(BOARD * BOARD);
    localparam int NUM_MOVES = BOARD * BOARD - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_tour = 1'b0;
    logic [7:0]       move;
    logic [15:0]      cmd_UART = 16'h0000;
    logic             cmd_rdy_UART = 1'b0;
    logic             clr_cmd_rdy = 1'b0;
    logic             send_resp = 1'b0;

    logic [IDX_W-1:0] mv_indx_a, mv_indx_b;
    logic [15:0]      cmd_a, cmd_b;
    logic             cmd_rdy_a, cmd_rdy_b;
    logic [7:0]       resp_a, resp_b;
    logic             busy_a, busy_b, err_a, err_b;

    logic [7:0] move_tab [NUM_MOVES];
    int DX [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int DY [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;
    int  rises  = 0;
    logic prev_rdy = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        move = 8'h00;
        if (int'(mv_indx_a) < NUM_MOVES) move = move_tab[mv_indx_a];
    end

    tour_cmd_seq #(.BOARD(BOARD), .FANFARE_LEG(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start_tour(start_tour), .move(move), .mv_indx(mv_indx_a),
        .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp(send_resp), .cmd(cmd_a), .cmd_rdy(cmd_rdy_a), .resp(resp_a),
        .tour_busy(busy_a), .tour_err(err_a)
    );

    tour_cmd_seq #(.BOARD(BOARD), .FANFARE_LEG(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start_tour(start_tour), .move(move), .mv_indx(mv_indx_b),
        .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp(send_resp), .cmd(cmd_b), .cmd_rdy(cmd_rdy_b), .resp(resp_b),
        .tour_busy(busy_b), .tour_err(err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Tour progress: fetching a move, a leg offered, or a leg executing downstream.
    bit m_busy = 1'b0;
    bit m_err  = 1'b0;
    int m_idx  = 0;
    int m_leg  = 0;
    int m_phase = 0;

    function automatic logic [15:0] leg_cmd(input logic [7:0] mv, input int leg, input bit fan);
        int b, dx, dy, mag;
        logic [3:0] op;
        logic [7:0] hd;
        b = 0;
        for (int i = 0; i < 8; i++) if (mv[i]) b = i;
        dx = DX[b];
        dy = DY[b];
        if (leg == 0) begin
            op  = fan ? 4'h2 : 4'h3;
            hd  = (dy > 0) ? 8'h00 : 8'h7F;
            mag = (dy < 0) ? -dy : dy;
        end else begin
            op  = fan ? 4'h3 : 4'h2;
            hd  = (dx > 0) ? 8'hBF : 8'h3F;
            mag = (dx < 0) ? -dx : dx;
        end
        return {op, hd, mag[3:0]};
    endfunction

    function automatic logic exp_rdy();
        return m_busy ? (m_phase == 1) : cmd_rdy_UART;
    endfunction

    function automatic logic [7:0] exp_resp();
        if (!m_busy) return 8'hA5;
        if (m_phase == 2 && m_leg == 1 && m_idx == NUM_MOVES - 1) return 8'hA5;
        return 8'h5A;
    endfunction

    function automatic logic [15:0] exp_cmd(input bit fan);
        if (!m_busy) return cmd_UART;
        return leg_cmd(move_tab[m_idx], m_leg, fan);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_err <= 1'b0; m_idx <= 0; m_leg <= 0; m_phase <= 0;
        end else begin
            m_err <= 1'b0;
            if (!m_busy) begin
                if (start_tour) begin
                    m_busy <= 1'b1; m_idx <= 0; m_phase <= 0;
                end
            end else if (cmd_rdy_UART && cmd_UART[15:12] == 4'hF) begin
                m_busy <= 1'b0; m_idx <= 0; m_err <= 1'b1;
            end else if (m_phase == 0) begin
                if ($countones(move_tab[m_idx]) != 1) begin
                    m_busy <= 1'b0; m_err <= 1'b1;
                end else begin
                    m_leg <= 0; m_phase <= 1;
                end
            end else if (m_phase == 1) begin
                if (clr_cmd_rdy) m_phase <= 2;
            end else if (send_resp) begin
                if (m_leg == 0) begin
                    m_leg <= 1; m_phase <= 1;
                end else if (m_idx == NUM_MOVES - 1) begin
                    m_busy <= 1'b0;
                end else begin
                    m_idx <= m_idx + 1; m_phase <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mv_indx_a", 32'(mv_indx_a), m_idx);
            check("mv_indx_b", 32'(mv_indx_b), m_idx);
            check("busy_a", busy_a, m_busy);
            check("busy_b", busy_b, m_busy);
            check("err_a", err_a, m_err);
            check("err_b", err_b, m_err);
            check("resp_a", resp_a, exp_resp());
            check("resp_b", resp_b, exp_resp());
            check("cmd_rdy_a", cmd_rdy_a, exp_rdy());
            check("cmd_rdy_b", cmd_rdy_b, exp_rdy());
            if (!m_busy || m_phase == 1) begin
                check("cmd_a", cmd_a, exp_cmd(1'b1));
                check("cmd_b", cmd_b, exp_cmd(1'b0));
            end
        end
        if (busy_a && cmd_rdy_a && !prev_rdy) rises <= rises + 1;
        prev_rdy <= busy_a && cmd_rdy_a;
    end

    task automatic noise();
        cmd_UART     = {4'($urandom_range(0, 14)), 12'($urandom)};
        cmd_rdy_UART = 1'($urandom_range(0, 1));
    endtask

    task automatic quiet();
        cmd_UART     = 16'h0000;
        cmd_rdy_UART = 1'b0;
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        while (cmd_rdy_a !== 1'b1 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        if (cmd_rdy_a !== 1'b1) begin
            n_cmp++; n_fail++;
            $display("FAIL leg_wait: got no cmd_rdy expected cmd_rdy within 60 cycles");
        end
    endtask

    task automatic do_leg(output logic [15:0] got_a, output logic [15:0] got_b);
        wait_rdy();
        got_a = cmd_a;
        got_b = cmd_b;
        repeat ($urandom_range(0, 3)) begin noise(); @(posedge clk); #1; end
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b0;
        repeat ($urandom_range(0, 3)) begin
            noise();
            clr_cmd_rdy = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b1;
        @(posedge clk); #1;
        send_resp = 1'b0;
    endtask

    task automatic fill_tab();
        for (int i = 0; i < NUM_MOVES; i++) move_tab[i] = 8'h01 << $urandom_range(0, 7);
    endtask

    task automatic pulse_start();
        start_tour = 1'b1;
        @(posedge clk); #1;
        start_tour = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ga, gb;
        int base;

        fill_tab();
        move_tab[0] = 8'h01;
        move_tab[1] = 8'h08;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mv_indx", 32'(mv_indx_a), 0);
        check("rst_cmd_rdy", cmd_rdy_a, 0);
        check("rst_resp", resp_a, 8'hA5);
        check("rst_busy", busy_a, 0);
        check("rst_err", err_a, 0);
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Full tour with random responder.
        base = rises;
        pulse_start();
        check("load_busy", busy_a, 1);
        check("load_rdy", cmd_rdy_a, 0);
        @(posedge clk); #1;
        check("first_rdy", cmd_rdy_a, 1);
        for (int m = 0; m < NUM_MOVES; m++) begin
            for (int leg = 0; leg < 2; leg++) begin
                do_leg(ga, gb);
                if (m == 0 && leg == 0) begin
                    check("m0_vert_a", ga, 16'h2002);
                    check("m0_vert_b", gb, 16'h3002);
                end
                if (m == 0 && leg == 1) begin
                    check("m0_horz_a", ga, 16'h3BF1);
                    check("m0_horz_b", gb, 16'h2BF1);
                    check("mv_indx_step", 32'(mv_indx_a), 1);
                end
                if (m == 1 && leg == 0) begin
                    check("m1_vert_a", ga, 16'h27F1);
                    check("m1_vert_b", gb, 16'h37F1);
                end
                if (m == 1 && leg == 1) begin
                    check("m1_horz_a", ga, 16'h33F2);
                    check("m1_horz_b", gb, 16'h23F2);
                end
            end
        end
        check("tour_end_busy", busy_a, 0);
        check("tour_end_resp", resp_a, 8'hA5);
        quiet();
        @(posedge clk); #1;
        check("cmd_count", rises - base, 48);

        // Invalid move at index 5.
        fill_tab();
        move_tab[5] = 8'h03;
        pulse_start();
        for (int m = 0; m < 5; m++) begin
            do_leg(ga, gb);
            do_leg(ga, gb);
        end
        quiet();
        check("err_load_idx", 32'(mv_indx_a), 5);
        @(posedge clk); #1;
        check("err_pulse", err_a, 1);
        check("err_busy", busy_a, 0);
        cmd_UART     = 16'h2101;
        cmd_rdy_UART = 1'b1;
        #1;
        check("pass_cmd", cmd_a, 16'h2101);
        check("pass_rdy", cmd_rdy_a, 1);
        @(posedge clk); #1;
        check("err_cleared", err_a, 0);
        quiet();

        // Abort during WAIT_V of move 3.
        fill_tab();
        pulse_start();
        for (int m = 0; m < 3; m++) begin
            do_leg(ga, gb);
            do_leg(ga, gb);
        end
        quiet();
        wait_rdy();
        cmd_UART     = 16'h2101;
        cmd_rdy_UART = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("ignore_busy", busy_a, 1);
        check("ignore_rdy", cmd_rdy_a, 1);
        quiet();
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1;
        clr_cmd_rdy  = 1'b0;
        cmd_UART     = 16'hF000;
        cmd_rdy_UART = 1'b1;
        @(posedge clk); #1;
        quiet();
        #1;
        check("abort_busy", busy_a, 0);
        check("abort_idx", 32'(mv_indx_a), 0);
        check("abort_rdy", cmd_rdy_a, 0);
        check("abort_err", err_a, 1);
        @(posedge clk); #1;

        // Asynchronous reset during VERT of move 1, then a fresh full tour.
        fill_tab();
        pulse_start();
        do_leg(ga, gb);
        do_leg(ga, gb);
        quiet();
        wait_rdy();
        #2;
        rst = 1'b1;
        #1;
        check("arst_rdy", cmd_rdy_a, 0);
        check("arst_cmd", cmd_a, 16'h0000);
        check("arst_resp", resp_a, 8'hA5);
        check("arst_busy", busy_a, 0);
        check("arst_idx", 32'(mv_indx_a), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        base = rises;
        pulse_start();
        check("restart_idx", 32'(mv_indx_a), 0);
        for (int m = 0; m < NUM_MOVES; m++) begin
            do_leg(ga, gb);
            do_leg(ga, gb);
        end
        quiet();
        @(posedge clk); #1;
        check("cmd_count2", rises - base, 48);
        check("tour2_busy", busy_a, 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
